// File: rtl/soc_evt_dc_src.sv
// Producer side of a toggle-token event crossing: events land in per-slot registers,
// and each slot's ownership flips by toggling its write token against the consumer's read pointer.
module soc_evt_dc_src #(
    parameter int BUFFER_WIDTH = 8,
    parameter int EVNT_WIDTH   = 8
) (
    input  logic                               clk_i,
    input  logic                               rstn_i,
    input  logic                               evt_valid_i,
    input  logic [EVNT_WIDTH-1:0]              evt_data_i,
    output logic                               evt_ready_o,
    output logic [BUFFER_WIDTH-1:0]            writetoken_o,
    input  logic [BUFFER_WIDTH-1:0]            readpointer_i,
    output logic [BUFFER_WIDTH*EVNT_WIDTH-1:0] data_async_o,
    output logic [$clog2(BUFFER_WIDTH):0]      fill_o,
    output logic                               idle_o
);

    localparam int IDX_W  = $clog2(BUFFER_WIDTH);
    localparam int FILL_W = $clog2(BUFFER_WIDTH) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BUFFER_WIDTH - 1);

    logic [BUFFER_WIDTH-1:0]                 rp_meta;
    logic [BUFFER_WIDTH-1:0]                 rp_sync;
    logic [BUFFER_WIDTH-1:0]                 occupied;
    logic [BUFFER_WIDTH-1:0][EVNT_WIDTH-1:0] slots;
    logic [IDX_W-1:0]                        wr_idx;
    logic                                    accept;

    // Each bit is an independent toggle, so per-bit synchronization is safe:
    // a slot's release is only ever seen late, never falsely.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rp_meta <= '0;
            rp_sync <= '0;
        end else begin
            rp_meta <= readpointer_i;
            rp_sync <= rp_meta;
        end
    end

    assign occupied    = writetoken_o ^ rp_sync;
    assign evt_ready_o = ~occupied[wr_idx];
    assign accept      = evt_valid_i & evt_ready_o;

    // Slot storage is reset as well, so the consumer never sees X on data_async_o.
    // NOTE: the slot array is reset on purpose; this keeps it in flops rather than a RAM macro.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            slots        <= '0;
            writetoken_o <= '0;
            wr_idx       <= '0;
        end else if (accept) begin
            slots[wr_idx]        <= evt_data_i;
            writetoken_o[wr_idx] <= ~writetoken_o[wr_idx];
            wr_idx               <= (wr_idx == LAST_IDX) ? '0 : wr_idx + 1'b1;
        end
    end

    assign data_async_o = slots;

    // NOTE: fill starts from a default before the loop, so no latch is inferred.
    always_comb begin
        fill_o = '0;
        for (int i = 0; i < BUFFER_WIDTH; i++) begin
            fill_o = fill_o + FILL_W'(occupied[i]);
        end
    end

    assign idle_o = (fill_o == '0);

endmodule

// File: tb/tb_soc_evt_dc_src.sv
// Directed bench for soc_evt_dc_src: scoreboard of accepted events plus a small token model.
module tb_soc_evt_dc_src;

    localparam int BW = 8;
    localparam int EW = 8;

    typedef struct {
        int         slot;
        logic [7:0] data;
    } sb_entry_t;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          evt_valid = 1'b0;
    logic [EW-1:0] evt_data = '0;
    logic          evt_ready;
    logic [BW-1:0] writetoken;
    logic [BW-1:0] readpointer = '0;
    logic [BW*EW-1:0] data_async;
    logic [3:0]    fill;
    logic          idle;

    int errors = 0;
    int checks = 0;

    sb_entry_t  sb[$];
    logic [7:0] model_wt;
    int         model_idx;
    logic [7:0] model_mem [BW];

    soc_evt_dc_src #(.BUFFER_WIDTH(BW), .EVNT_WIDTH(EW)) dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .evt_valid_i  (evt_valid),
        .evt_data_i   (evt_data),
        .evt_ready_o  (evt_ready),
        .writetoken_o (writetoken),
        .readpointer_i(readpointer),
        .data_async_o (data_async),
        .fill_o       (fill),
        .idle_o       (idle)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model_data();
        logic [63:0] v;
        for (int i = 0; i < BW; i++) v[i*EW +: EW] = model_mem[i];
        return v;
    endfunction

    task automatic model_reset();
        model_wt  = '0;
        model_idx = 0;
        for (int i = 0; i < BW; i++) model_mem[i] = '0;
        sb.delete();
    endtask

    // Called at a falling edge; returns one falling edge after the accepting rising edge.
    task automatic write_evt(input logic [7:0] d);
        int waited = 0;
        evt_valid = 1'b1;
        evt_data  = d;
        while (!evt_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!evt_ready) begin
            check("accept_timeout", 64'd0, 64'd1);
            evt_valid = 1'b0;
            return;
        end
        sb.push_back('{model_idx, d});
        model_mem[model_idx] = d;
        model_wt[model_idx]  = ~model_wt[model_idx];
        model_idx            = (model_idx + 1) % BW;
        @(negedge clk);
    endtask

    task automatic drain_sb();
        sb_entry_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check($sformatf("slot%0d", e.slot), 64'(data_async[e.slot*EW +: EW]), 64'(e.data));
        end
    endtask

    task automatic do_reset();
        evt_valid   = 1'b0;
        rstn        = 1'b0;
        readpointer = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        // Reset state, then the first event goes in on the first edge after release.
        model_reset();
        do_reset();
        #1;
        check("rst_wt",    64'(writetoken), 64'h00);
        check("rst_ready", 64'(evt_ready),  64'd1);
        check("rst_fill",  64'(fill),       64'd0);
        check("rst_idle",  64'(idle),       64'd1);
        check("rst_data",  data_async,      64'd0);

        // Burst of three back-to-back events.
        write_evt(8'hA1);
        write_evt(8'hA2);
        write_evt(8'hA3);
        evt_valid = 1'b0;
        check("burst_wt",   64'(writetoken), 64'h07);
        check("burst_fill", 64'(fill),       64'd3);
        check("burst_idle", 64'(idle),       64'd0);
        check("burst_data", data_async,      model_data());
        drain_sb();

        // Fill all slots, hold a ninth event for 20 cycles.
        do_reset();
        for (int i = 0; i < BW; i++) write_evt(8'h10 + 8'(i));
        evt_valid = 1'b0;
        check("full_wt",    64'(writetoken), 64'hFF);
        check("full_ready", 64'(evt_ready),  64'd0);
        check("full_fill",  64'(fill),       64'd8);
        drain_sb();
        evt_valid = 1'b1;
        evt_data  = 8'h55;
        repeat (20) @(negedge clk);
        check("hold_wt",    64'(writetoken), 64'hFF);
        check("hold_ready", 64'(evt_ready),  64'd0);
        check("hold_data",  data_async,      model_data());

        // Release slot 0: ready must rise exactly two edges later.
        readpointer = 8'h01;
        @(negedge clk);
        check("rel_ready_1", 64'(evt_ready), 64'd0);
        @(negedge clk);
        check("rel_ready_2", 64'(evt_ready), 64'd1);
        check("rel_fill",    64'(fill),      64'd7);
        write_evt(8'h55);
        evt_valid = 1'b0;
        check("rel_wt",    64'(writetoken), 64'hFE);
        check("rel_fill2", 64'(fill),       64'd8);
        check("rel_ready", 64'(evt_ready),  64'd0);
        drain_sb();

        // Wrap-around: drain everything, write one, then prove wr_idx sits at slot 1.
        do_reset();
        for (int i = 0; i < BW; i++) write_evt(8'h20 + 8'(i));
        evt_valid   = 1'b0;
        readpointer = 8'hFF;
        repeat (3) @(negedge clk);
        check("wrap_empty", 64'(fill), 64'd0);
        check("wrap_idle",  64'(idle), 64'd1);
        sb.delete();
        write_evt(8'h77);
        evt_valid = 1'b0;
        check("wrap_wt",   64'(writetoken), 64'hFE);
        check("wrap_fill", 64'(fill),       64'd1);
        write_evt(8'h78);
        evt_valid = 1'b0;
        check("wrap_wt2",  64'(writetoken), 64'hFC);
        check("wrap_data", data_async,      model_data());
        drain_sb();

        // Reset in the middle of a burst takes effect without a clock edge.
        do_reset();
        for (int i = 0; i < 5; i++) write_evt(8'h30 + 8'(i));
        check("mid_wt_pre", 64'(writetoken), 64'h1F);
        drain_sb();
        #2 rstn = 1'b0;
        evt_valid = 1'b0;
        #1;
        check("mid_wt",    64'(writetoken), 64'h00);
        check("mid_fill",  64'(fill),       64'd0);
        check("mid_ready", 64'(evt_ready),  64'd1);
        check("mid_data",  data_async,      64'd0);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/soc_evt_dc_src.md
SOC_EVT_DC_SRC -- requirements
Module: soc_evt_dc_src

Interface
REQ-001 SHALL have parameter BUFFER_WIDTH, default 8: number of event slots and width of the token/pointer vectors; legal range 2..32.
REQ-002 SHALL have parameter EVNT_WIDTH, default 8: width of one event word.
REQ-003 SHALL have port clk_i, input, 1: single block clock; every register is clocked on its rising edge.
REQ-004 SHALL have port rstn_i, input, 1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port evt_valid_i, input, 1: an event is offered this cycle.
REQ-006 SHALL have port evt_data_i, input, EVNT_WIDTH: payload of the offered event.
REQ-007 SHALL have port evt_ready_o, output, 1: a free slot exists, so the offered event is accepted this cycle.
REQ-008 SHALL have port writetoken_o, output, BUFFER_WIDTH: per-slot write toggle vector sent to the consumer domain.
REQ-009 SHALL have port readpointer_i, input, BUFFER_WIDTH: per-slot read toggle vector from the consumer domain; asynchronous to clk_i.
REQ-010 SHALL have port data_async_o, output, BUFFER_WIDTH*EVNT_WIDTH: slot contents, flattened; slot i occupies bits [i*EVNT_WIDTH +: EVNT_WIDTH].
REQ-011 SHALL have port fill_o, output, $clog2(BUFFER_WIDTH)+1: number of occupied slots as seen locally.
REQ-012 SHALL have port idle_o, output, 1: high when fill_o equals 0.

Function
REQ-013 SHALL synchronize readpointer_i through a 2-flop synchronizer per bit (rp_sync); a toggle at the input is visible in rp_sync after the second rising edge.
REQ-014 SHALL define slot i as occupied if and only if writetoken_o[i] differs from rp_sync[i].
REQ-015 SHALL hold a write index wr_idx (0..BUFFER_WIDTH-1).
REQ-016 SHALL drive evt_ready_o high if and only if slot wr_idx is free; the value is combinational from registers only.
REQ-017 SHALL update three things at the same edge when evt_valid_i and evt_ready_o are both high: write evt_data_i into slot wr_idx, toggle writetoken_o[wr_idx], and advance wr_idx.
REQ-018 SHALL advance wr_idx from BUFFER_WIDTH-1 to 0; it need not be a power of two.
REQ-019 SHALL leave all state unchanged when evt_valid_i is high and evt_ready_o is low; the producer holds evt_data_i until accepted.
REQ-020 SHALL register writetoken_o and data_async_o directly, with no combinational logic on the output path.
REQ-021 SHALL keep the contents of slot i stable for as long as slot i is occupied.
REQ-022 SHALL compute fill_o as the popcount of (writetoken_o XOR rp_sync).
REQ-023 SHALL leave fill_o unchanged when a write and a synchronized slot release occur in the same cycle.
REQ-024 SHALL keep evt_ready_o low while all BUFFER_WIDTH slots are occupied; it rises 2 cycles after the release toggle of slot wr_idx.
REQ-025 SHALL ignore toggles on readpointer_i for free slots, which indicate a consumer protocol error; they SHALL only affect fill_o and evt_ready_o through REQ-014.

Reset
REQ-026 SHALL, while rstn_i is low, asynchronously clear the following to 0: writetoken_o, all slots, wr_idx and both synchronizer stages.
REQ-027 SHALL therefore reset outputs to: evt_ready_o=1, fill_o=0, idle_o=1, data_async_o=0.
REQ-028 SHALL, on reset asserted mid-transfer, discard all pending events; the consumer domain SHALL be reset together so that readpointer_i returns to 0.
REQ-029 SHALL accept the first event on the first rising edge after rstn_i is released.

Verification
REQ-030 SHALL cover reset: after rstn_i is released with readpointer_i=0 -> writetoken_o=0x00, evt_ready_o=1, fill_o=0, idle_o=1.
REQ-031 SHALL cover a burst: 3 back-to-back events 0xA1, 0xA2, 0xA3 -> writetoken_o=0x07, slots 0..2 hold 0xA1/0xA2/0xA3, fill_o=3, idle_o=0.
REQ-032 SHALL cover full: 8 writes with no reads -> writetoken_o=0xFF, evt_ready_o=0, fill_o=8; a 9th event is held with no state change for 20 cycles.
REQ-033 SHALL cover release when full: readpointer_i=0x01 -> evt_ready_o rises exactly 2 cycles later; the held event is then written to slot 0 and writetoken_o=0xFE.
REQ-034 SHALL cover wrap-around: 8 writes, readpointer_i=0xFF, one more write -> writetoken_o=0xFE, fill_o=1, and wr_idx wraps to 1.
REQ-035 SHALL cover reset mid-burst: rstn_i asserted after 5 writes -> writetoken_o=0, fill_o=0 and evt_ready_o=1 immediately, without waiting for a clock edge.
